mult_issue: RTL and testbench

MULT_ISSUE -- requirements
Module: mult_issue

---
 rtl/mult_issue.sv | 145 ++++++++++++++
 tb/tb_mult_issue.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue.sv
`default_nettype none
// ============================================================================
// Module      : mult_issue
// Description : Single-outstanding operand issuer for an external multiplier.
//               IDLE -> ISSUE -> HOLD; optional ISSUE watchdog enabled by
//               defining MULT_ISSUE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_issue #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    output logic        mul_start,
    input  logic        mul_done,
    input  logic [15:0] mul_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_mul_start;
    logic        r_out_valid;
    logic        r_busy;
    logic [7:0]  r_mul_a;
    logic [7:0]  r_mul_b;
    logic [15:0] r_out_result;

    if ((TIMEOUT < 5) || (TIMEOUT > 255)) begin : g_timeout_range
        $error("mult_issue: TIMEOUT must lie in 5..255");
    end

`ifdef MULT_ISSUE_TIMEOUT_EN
    // Abort fires on the ISSUE edge where the count has reached TIMEOUT-1,
    // i.e. after exactly TIMEOUT cycles of mul_start high.
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_tmo_cnt;
    logic       r_out_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b1;
            r_mul_start  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_mul_a      <= 8'd0;
            r_mul_b      <= 8'd0;
            r_out_result <= 16'd0;
`ifdef MULT_ISSUE_TIMEOUT_EN
            r_tmo_cnt    <= 8'd0;
            r_out_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mul_a     <= in_a;
                        r_mul_b     <= in_b;
                        r_mul_start <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
`ifdef MULT_ISSUE_TIMEOUT_EN
                        r_tmo_cnt   <= 8'd0;
`endif
                    end
                end

                ST_ISSUE: begin
                    if (mul_done) begin
                        r_out_result <= mul_result;
                        r_mul_start  <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_state      <= ST_HOLD;
`ifdef MULT_ISSUE_TIMEOUT_EN
                        r_out_err    <= 1'b0;
                    end else if (r_tmo_cnt == C_TMO_LAST) begin
                        r_out_result <= 16'd0;
                        r_mul_start  <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_out_err    <= 1'b1;
                        r_state      <= ST_HOLD;
                    end else begin
                        r_tmo_cnt    <= r_tmo_cnt + 8'd1;
`endif
                    end
                end

                ST_HOLD: begin
                    // in_ready returns only after the product has left,
                    // so there is never a same-edge bypass into ISSUE.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_mul_start <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_start  = r_mul_start;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign busy       = r_busy;

`ifdef MULT_ISSUE_TIMEOUT_EN
    assign out_err = r_out_err;
`else
    assign out_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_issue
// Description : Directed self-checking bench for mult_issue with a 4-cycle
//               multiplier model (done rises 4 cycles after mul_start rises).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_start;
    logic        mul_done;
    logic [15:0] mul_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // multiplier model and manual done injection
    logic        model_en   = 1'b1;
    logic        model_busy = 1'b0;
    logic        model_done = 1'b0;
    logic [1:0]  model_cnt  = 2'd0;
    logic [15:0] model_prod = 16'd0;
    logic        force_done = 1'b0;
    logic [15:0] force_res  = 16'd0;

    assign mul_done   = model_done | force_done;
    assign mul_result = force_done ? force_res : model_prod;

    mult_issue #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (model_done) begin
            model_done <= 1'b0;
        end else if (model_busy) begin
            if (model_cnt == 2'd3) begin
                model_done <= 1'b1;
                model_busy <= 1'b0;
            end else begin
                model_cnt <= model_cnt + 2'd1;
            end
        end else if (mul_start && model_en) begin
            model_busy <= 1'b1;
            model_cnt  <= 2'd1;
            model_prod <= {8'd0, mul_a} * {8'd0, mul_b};
        end
    end

    // Issue one operand pair; returns at the negedge where out_valid is seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] res, output logic err,
                          output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (out_valid !== 1'b1 && lat < 40);
        res = out_result;
        err = out_err;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_a = 8'h11; in_b = 8'h22; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({mul_start, out_valid, out_err, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: start/valid/err/busy=%b required 0000",
                               {mul_start, out_valid, out_err, busy});
        end
        n_tests++;
        if ({out_result, mul_a, mul_b} !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: result=%h a=%h b=%h required all 0",
                               out_result, mul_a, mul_b);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic;
        int   lat;
        logic ops_ok;
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_idle_ready: got %b required 1", in_ready);
        end
        in_a = 8'd3; in_b = 8'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_a = 8'hAA; in_b = 8'h55;
        n_tests++;
        if ({busy, mul_start, in_ready} !== 3'b110) begin
            n_fail++; $display("FAIL basic_issue_flags: busy/start/ready=%b required 110",
                               {busy, mul_start, in_ready});
        end
        lat = 1; ops_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (mul_a !== 8'd3 || mul_b !== 8'd5) ops_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (ops_ok !== 1'b1) begin
            n_fail++; $display("FAIL basic_operands_held: a=%h b=%h required 03 05", mul_a, mul_b);
        end
        n_tests++;
        if (lat != 6) begin
            n_fail++; $display("FAIL basic_latency: got %0d cycles required 6", lat);
        end
        n_tests++;
        if (out_result !== 16'd15 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL basic_result: got %h err %b required 000f err 0", out_result, out_err);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_valid_width: out_valid=%b required 0 after 1 cycle", out_valid);
        end
    endtask

    task automatic test_products;
        logic [15:0] res;
        logic        err;
        int          lat;
        out_ready = 1'b1;
        run_op(8'hFF, 8'hFF, res, err, lat);
        n_tests++;
        if (res !== 16'hFE01 || err !== 1'b0 || lat != 6) begin
            n_fail++; $display("FAIL prod_ff_ff: got %h err %b lat %0d required fe01 err 0 lat 6", res, err, lat);
        end
        run_op(8'h00, 8'hAB, res, err, lat);
        n_tests++;
        if (res !== 16'h0000 || err !== 1'b0) begin
            n_fail++; $display("FAIL prod_00_ab: got %h err %b required 0000 err 0", res, err);
        end
        // stray done while IDLE
        @(negedge clk);
        force_res = 16'hDEAD; force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        n_tests++;
        if ({out_valid, busy, in_ready} !== 3'b001 || out_result !== 16'h0000) begin
            n_fail++; $display("FAIL idle_done_ignored: valid/busy/ready=%b result=%h required 001 0000",
                               {out_valid, busy, in_ready}, out_result);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic [15:0] ve [4];
        int k, last_ov, low_run, min_low;
        logic seen_start;
        va[0] = 8'd2;   vb[0] = 8'd7;   ve[0] = 16'd14;
        va[1] = 8'h10;  vb[1] = 8'h10;  ve[1] = 16'h0100;
        va[2] = 8'hFF;  vb[2] = 8'h01;  ve[2] = 16'h00FF;
        va[3] = 8'h80;  vb[3] = 8'h02;  ve[3] = 16'h0100;
        k = 0; last_ov = 0; low_run = 0; min_low = 99; seen_start = 1'b0;
        out_ready = 1'b1;
        in_a = va[0]; in_b = vb[0]; in_valid = 1'b1;
        for (int cyc = 0; cyc < 80 && k < 4; cyc++) begin
            @(negedge clk);
            if (mul_start === 1'b1) begin
                if (seen_start && low_run > 0 && low_run < min_low) min_low = low_run;
                seen_start = 1'b1;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (out_valid === 1'b1) begin
                n_tests++;
                if (out_result !== ve[k]) begin
                    n_fail++; $display("FAIL b2b_result[%0d]: got %h required %h", k, out_result, ve[k]);
                end
                if (k > 0) begin
                    n_tests++;
                    if (cyc - last_ov != 7) begin
                        n_fail++; $display("FAIL b2b_period[%0d]: got %0d cycles required 7", k, cyc - last_ov);
                    end
                end
                last_ov = cyc;
                k++;
                if (k < 4) begin
                    in_a = va[k]; in_b = vb[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (k != 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d products required 4", k);
        end
        n_tests++;
        if (min_low < 2 || min_low == 99) begin
            n_fail++; $display("FAIL b2b_start_gap: shortest mul_start low run %0d required >=2", min_low);
        end
        @(negedge clk);
    endtask

    task automatic test_hold_stall;
        logic [15:0] res;
        logic        err;
        int          lat;
        logic        res_ok, rdy_ok, start_ok;
        out_ready = 1'b0;
        run_op(8'h12, 8'h34, res, err, lat);
        n_tests++;
        if (res !== 16'h03A8) begin
            n_fail++; $display("FAIL stall_result: got %h required 03a8", res);
        end
        res_ok = 1'b1; rdy_ok = 1'b1; start_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_result !== 16'h03A8 || out_valid !== 1'b1) res_ok = 1'b0;
            if (in_ready !== 1'b0) rdy_ok = 1'b0;
            if (mul_start !== 1'b0) start_ok = 1'b0;
            in_a = 8'(i * 37 + 1); in_b = 8'(i * 11 + 9); in_valid = 1'b1;
            force_res = 16'hBEEF; force_done = (i == 4);
            @(negedge clk);
        end
        force_done = 1'b0;
        n_tests++;
        if (res_ok !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold_result: got %h valid %b required 03a8 valid 1", out_result, out_valid);
        end
        n_tests++;
        if (rdy_ok !== 1'b1) begin
            n_fail++; $display("FAIL stall_in_ready: got %b required 0 throughout", in_ready);
        end
        n_tests++;
        if (start_ok !== 1'b1) begin
            n_fail++; $display("FAIL stall_no_start: got %b required 0 throughout", mul_start);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: valid %b ready %b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] res;
        logic        err;
        int          lat;
        out_ready = 1'b1;
        @(negedge clk);
        in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if ({mul_start, busy, in_ready, out_valid} !== 4'b0010 || mul_a !== 8'd0) begin
            n_fail++; $display("FAIL reset_issue: start/busy/ready/valid=%b a=%h required 0010 00",
                               {mul_start, busy, in_ready, out_valid}, mul_a);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({out_valid, busy, mul_start} !== 3'b000 || out_result !== 16'd0) begin
            n_fail++; $display("FAIL reset_late_done: valid/busy/start=%b result=%h required 000 0000",
                               {out_valid, busy, mul_start}, out_result);
        end
        out_ready = 1'b0;
        run_op(8'd7, 8'd6, res, err, lat);
        n_tests++;
        if (res !== 16'd42) begin
            n_fail++; $display("FAIL reset_hold_pre: got %h required 002a", res);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        n_tests++;
        if ({out_valid, out_err, in_ready} !== 3'b001 || out_result !== 16'd0) begin
            n_fail++; $display("FAIL reset_hold: valid/err/ready=%b result=%h required 001 0000",
                               {out_valid, out_err, in_ready}, out_result);
        end
    endtask

`ifdef MULT_ISSUE_TIMEOUT_EN
    task automatic test_timeout;
        int starts, cyc;
        model_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_a = 8'd2; in_b = 8'd2; in_valid = 1'b1;
        starts = 0; cyc = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            if (mul_start === 1'b1) starts++;
            cyc++;
        end while (out_valid !== 1'b1 && cyc < 40);
        n_tests++;
        if (starts != 8) begin
            n_fail++; $display("FAIL timeout_start_cycles: got %0d required 8", starts);
        end
        n_tests++;
        if (out_err !== 1'b1 || out_result !== 16'd0 || mul_start !== 1'b0) begin
            n_fail++; $display("FAIL timeout_abort: err %b result %h start %b required 1 0000 0",
                               out_err, out_result, mul_start);
        end
        @(negedge clk);
        in_a = 8'd3; in_b = 8'd3; in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (i == 8) begin
                force_res = 16'h1234; force_done = 1'b1;
            end
        end
        @(negedge clk);
        force_done = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || out_result !== 16'h1234) begin
            n_fail++; $display("FAIL timeout_done_priority: valid %b err %b result %h required 1 0 1234",
                               out_valid, out_err, out_result);
        end
        @(negedge clk);
        model_en = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_back_to_back();
        test_hold_stall();
        test_reset_mid();
`ifdef MULT_ISSUE_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
